// File: rtl/cam_update_ctrl_if.sv
// Handshake and bus bundle between the password-manager front end, the update
// controller, the shadow erase RAM and the CAM.
interface cam_update_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_del;

  logic                  er_write;
  logic [ADDR_WIDTH-1:0] er_addr;
  logic [DATA_WIDTH-1:0] er_data;
  logic                  er_erase;
  logic [DATA_WIDTH-1:0] er_old;

  logic                  cam_erase;
  logic                  cam_write;
  logic [ADDR_WIDTH-1:0] cam_addr;
  logic [DATA_WIDTH-1:0] cam_key;
  logic                  cam_ack;

  logic                  busy;
  logic                  done;
  logic                  err;

  // slave: the update controller
  modport slave (
    input  req_valid, req_addr, req_data, req_del,
    input  er_erase, er_old, cam_ack,
    output req_ready, er_write, er_addr, er_data,
    output cam_erase, cam_write, cam_addr, cam_key,
    output busy, done, err
  );

  // master: front end plus the CAM / erase-RAM pair driving the controller
  modport master (
    output req_valid, req_addr, req_data, req_del,
    output er_erase, er_old, cam_ack,
    input  req_ready, er_write, er_addr, er_data,
    input  cam_erase, cam_write, cam_addr, cam_key,
    input  busy, done, err
  );
endinterface

// File: rtl/cam_update_ctrl.sv
// CAM key-update sequencer: swap into the shadow erase RAM, erase the old key
// from the CAM, then write the new key, with a per-command ack timeout.
module cam_update_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst,
  cam_update_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_OLD,
    S_ERASE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_del;
  logic [CNT_W-1:0]      r_cnt;

  logic                  r_req_ready;
  logic                  r_er_write;
  logic [ADDR_WIDTH-1:0] r_er_addr;
  logic [DATA_WIDTH-1:0] r_er_data;
  logic                  r_cam_erase;
  logic                  r_cam_write;
  logic [ADDR_WIDTH-1:0] r_cam_addr;
  logic [DATA_WIDTH-1:0] r_cam_key;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  assign bus.req_ready = r_req_ready;
  assign bus.er_write  = r_er_write;
  assign bus.er_addr   = r_er_addr;
  assign bus.er_data   = r_er_data;
  assign bus.cam_erase = r_cam_erase;
  assign bus.cam_write = r_cam_write;
  assign bus.cam_addr  = r_cam_addr;
  assign bus.cam_key   = r_cam_key;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

  // Outputs are registered: each branch sets what the next state presents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_del       <= 1'b0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_er_write  <= 1'b0;
      r_er_addr   <= '0;
      r_er_data   <= '0;
      r_cam_erase <= 1'b0;
      r_cam_write <= 1'b0;
      r_cam_addr  <= '0;
      r_cam_key   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_er_write <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr      <= bus.req_addr;
            r_data      <= bus.req_data;
            r_del       <= bus.req_del;
            r_er_write  <= 1'b1;
            r_er_addr   <= bus.req_addr;
            r_er_data   <= bus.req_del ? '0 : bus.req_data;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            r_state     <= S_SWAP;
          end
        end

        S_SWAP: begin
          r_state <= S_OLD;
        end

        // Erase RAM presents the displaced key one cycle after the swap write.
        S_OLD: begin
          r_cnt <= '0;
          if (!bus.er_erase) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (bus.er_old == '0) begin
            if (r_del) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cam_write <= 1'b1;
              r_cam_key   <= r_data;
              r_cam_addr  <= r_addr;
              r_state     <= S_WRITE;
            end
          end else begin
            r_cam_erase <= 1'b1;
            r_cam_key   <= bus.er_old;
            r_cam_addr  <= r_addr;
            r_state     <= S_ERASE;
          end
        end

        S_ERASE: begin
          if (bus.cam_ack) begin
            r_cam_erase <= 1'b0;
            r_cnt       <= '0;
            if (r_del) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cam_write <= 1'b1;
              r_cam_key   <= r_data;
              r_cam_addr  <= r_addr;
              r_state     <= S_WRITE;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_cam_erase <= 1'b0;
            r_err       <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WRITE: begin
          if (bus.cam_ack) begin
            r_cam_write <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_cam_write <= 1'b0;
            r_err       <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          r_err       <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cam_update_ctrl.sv
// Directed bench for cam_update_ctrl with an erase-RAM model and an
// acknowledging CAM responder whose ack delay is set per test.
module tb_cam_update_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_update_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cam_update_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Erase RAM: swap write returns the displaced key with er_erase one cycle later
  logic [DW-1:0] er_mem [4] = '{default: '0};
  always @(posedge clk) begin
    bus.er_erase <= bus.er_write;
    if (bus.er_write) begin
      bus.er_old            <= er_mem[bus.er_addr];
      er_mem[bus.er_addr]   <= bus.er_data;
    end
  end

  // Monitor plus CAM responder; ack comes in the (ack_wait+1)th command cycle
  int ack_wait = 0;
  int clr_gen = 0, seen_gen = 0;
  int n_erw, n_ers, n_wrs, wr_hi, first_ers_cyc, first_wr_cyc, done_cyc;
  logic [DW-1:0] erw_data, ers_key, wr_key;
  logic [AW-1:0] erw_addr, ers_addr, wr_addr;
  bit overlap, done_seen, done_err, rdy_after, prev_done;
  int cmd_kind, prev_kind = 0, cmd_cnt = 0;

  always @(negedge clk) begin
    if (seen_gen != clr_gen) begin
      seen_gen = clr_gen;
      n_erw = 0; n_ers = 0; n_wrs = 0; wr_hi = 0;
      first_ers_cyc = 0; first_wr_cyc = 0; done_cyc = 0;
      erw_data = '0; ers_key = '0; wr_key = '0;
      erw_addr = '0; ers_addr = '0; wr_addr = '0;
      overlap = 0; done_seen = 0; done_err = 0; rdy_after = 0; prev_done = 0;
    end
    if (prev_done) rdy_after = bus.req_ready;
    prev_done = bus.done;
    if (bus.er_write) begin
      n_erw++; erw_data = bus.er_data; erw_addr = bus.er_addr;
    end
    if (bus.cam_erase && bus.cam_write) overlap = 1;
    if (bus.cam_erase && prev_kind != 1) begin
      n_ers++; ers_key = bus.cam_key; ers_addr = bus.cam_addr; first_ers_cyc = cyc;
    end
    if (bus.cam_write && prev_kind != 2) begin
      n_wrs++; wr_key = bus.cam_key; wr_addr = bus.cam_addr; first_wr_cyc = cyc;
    end
    if (bus.cam_write) wr_hi++;
    if (bus.done && !done_seen) begin
      done_seen = 1; done_cyc = cyc; done_err = bus.err;
    end
    cmd_kind = bus.cam_erase ? 1 : (bus.cam_write ? 2 : 0);
    if (cmd_kind == 0) cmd_cnt = 0;
    else if (cmd_kind != prev_kind) cmd_cnt = 1;
    else cmd_cnt++;
    prev_kind = cmd_kind;
    bus.cam_ack = (cmd_kind != 0) && (ack_wait >= 0) && (cmd_cnt == ack_wait + 1);
  end

  task automatic start_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit del, input bit hold, output int acc);
    int n;
    @(posedge clk); #2;
    clr_gen++;
    @(negedge clk); #1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n == 50) check("ready_wait", 0, 1);
    acc = cyc;
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_data = d; bus.req_del = del;
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int acc, output int lat);
    int n;
    n = 0;
    while (!done_seen && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!done_seen) check("done_wait", 0, 1);
    lat = done_cyc - acc;
    $display("txn: accept@%0d done@%0d latency=%0d err=%0b erase=%0d write=%0d",
             acc, done_cyc, lat, done_err, n_ers, n_wrs);
  endtask

  initial begin
    int acc, lat, n;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.req_del = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_cmds", {bus.er_write, bus.cam_erase, bus.cam_write}, 0);
    @(posedge clk); #2 rst = 1'b1;

    // T1: write into empty slot 1
    ack_wait = 2;
    start_req(2'd1, 8'h5A, 1'b0, 1'b0, acc);
    wait_done(acc, lat);
    check("t1_lat", lat, 6);
    check("t1_erw_n", n_erw, 1);
    check("t1_erw_addr", erw_addr, 1);
    check("t1_erw_data", erw_data, 8'h5A);
    check("t1_erase_n", n_ers, 0);
    check("t1_write_n", n_wrs, 1);
    check("t1_wr_key", wr_key, 8'h5A);
    check("t1_wr_addr", wr_addr, 1);
    check("t1_wr_hi", wr_hi, 3);
    check("t1_err", done_err, 0);

    // T2: rewrite slot 1, erase then write
    ack_wait = 1;
    start_req(2'd1, 8'h3C, 1'b0, 1'b0, acc);
    wait_done(acc, lat);
    check("t2_lat", lat, 7);
    check("t2_ers_key", ers_key, 8'h5A);
    check("t2_ers_addr", ers_addr, 1);
    check("t2_wr_key", wr_key, 8'h3C);
    check("t2_order", first_ers_cyc < first_wr_cyc, 1);
    check("t2_overlap", overlap, 0);
    check("t2_err", done_err, 0);

    // T3: delete slot 1
    ack_wait = 0;
    start_req(2'd1, 8'hEE, 1'b1, 1'b0, acc);
    wait_done(acc, lat);
    check("t3_lat", lat, 4);
    check("t3_erw_data", erw_data, 0);
    check("t3_ers_key", ers_key, 8'h3C);
    check("t3_write_n", n_wrs, 0);
    check("t3_err", done_err, 0);

    // T4: write never acknowledged
    ack_wait = -1;
    start_req(2'd0, 8'h77, 1'b0, 1'b0, acc);
    wait_done(acc, lat);
    check("t4_lat", lat, 3 + TO);
    check("t4_wr_hi", wr_hi, TO);
    check("t4_err", done_err, 1);
    @(negedge clk); #1;
    check("t4_ready_next", rdy_after, 1);
    check("t4_cmd_drop", bus.cam_write, 0);

    // T5: reset in the middle of an erase of slot 0 (holds 0x77)
    start_req(2'd0, 8'h99, 1'b0, 1'b0, acc);
    n = 0;
    while (!bus.cam_erase && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("t5_in_erase", bus.cam_erase, 1);
    check("t5_ers_key", ers_key, 8'h77);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("t5_rst_cmds", {bus.cam_erase, bus.cam_write}, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_ready", bus.req_ready, 1);
    @(posedge clk); #2 rst = 1'b1;
    ack_wait = 1;
    start_req(2'd0, 8'hAB, 1'b0, 1'b0, acc);
    wait_done(acc, lat);
    check("t5_lat", lat, 7);
    check("t5_ers_key2", ers_key, 8'h99);
    check("t5_wr_key", wr_key, 8'hAB);
    check("t5_err", done_err, 0);

    // T6: req_valid held with changing inputs while busy
    ack_wait = 1;
    start_req(2'd2, 8'h11, 1'b0, 1'b1, acc);
    n = 0;
    while (n < 100) begin
      @(posedge clk); #2;
      if (done_seen) break;
      bus.req_data = 8'hC0 ^ 8'(n);
      bus.req_addr = 2'(n);
      bus.req_del  = n[0];
      n++;
    end
    check("t6_done_seen", done_seen, 1);
    check("t6_lat", done_cyc - acc, 5);
    check("t6_wr_key", wr_key, 8'h11);
    check("t6_wr_addr", wr_addr, 2);
    bus.req_data = 8'h22; bus.req_addr = 2'd3; bus.req_del = 1'b0;
    lat = done_cyc;
    clr_gen++;
    @(negedge clk); #1;
    check("t6_ready", bus.req_ready, 1);
    check("t6_accept_gap", cyc - lat, 1);
    acc = cyc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_done(acc, lat);
    check("t6b_lat", lat, 5);
    check("t6b_wr_key", wr_key, 8'h22);
    check("t6b_wr_addr", wr_addr, 3);
    check("t6b_err", done_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
